// File: rtl/passcode_controller.sv
// rtl/passcode_controller.sv - three-pair BCD passcode entry FSM with timed open and lockout states
module passcode_controller #(
    parameter logic [23:0] PASSCODE    = 24'h123456,
    parameter int          MAX_FAIL    = 3,
    parameter logic [15:0] OPEN_CYCLES = 16'd50000,
    parameter logic [15:0] LOCK_CYCLES = 16'd65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        clr,
    input  logic [7:0]  sw,
    output logic [1:0]  stage,
    output logic [23:0] entry,
    output logic        unlocked,
    output logic        locked_out,
    output logic [1:0]  fail_cnt,
    output logic        err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_E0,
        S_E1,
        S_E2,
        S_CHECK,
        S_OPEN,
        S_FAIL,
        S_LOCKOUT
    } state_t;

    localparam logic [23:0] ENTRY_EMPTY = 24'hFFFFFF;

    state_t      state;
    state_t      state_next;
    logic [23:0] entry_next;
    logic [1:0]  fail_next;
    logic [15:0] timer;
    logic [15:0] timer_next;
    logic        err_next;
    logic        push_q;
    logic        push_edge;
    logic        sw_valid;
    logic [1:0]  fail_inc;

    assign push_edge = push & ~push_q;
    assign sw_valid  = (sw[7:4] <= 4'd9) && (sw[3:0] <= 4'd9);
    assign fail_inc  = (fail_cnt == 2'd3) ? 2'd3 : fail_cnt + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_E0;
            entry    <= ENTRY_EMPTY;
            fail_cnt <= 2'd0;
            timer    <= 16'd0;
            err      <= 1'b0;
            // Treat a push held through reset as already seen.
            push_q   <= 1'b1;
        end else begin
            state    <= state_next;
            entry    <= entry_next;
            fail_cnt <= fail_next;
            timer    <= timer_next;
            err      <= err_next;
            push_q   <= push;
        end
    end

    always_comb begin
        state_next = state;
        entry_next = entry;
        fail_next  = fail_cnt;
        timer_next = timer;
        err_next   = 1'b0;
        case (state)
            S_E0: begin
                if (push_edge) begin
                    if (sw_valid) begin
                        entry_next[23:16] = sw;
                        state_next        = S_E1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_E1: begin
                if (clr) begin
                    entry_next = ENTRY_EMPTY;
                    state_next = S_E0;
                end else if (push_edge) begin
                    if (sw_valid) begin
                        entry_next[15:8] = sw;
                        state_next       = S_E2;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_E2: begin
                if (clr) begin
                    entry_next = ENTRY_EMPTY;
                    state_next = S_E0;
                end else if (push_edge) begin
                    if (sw_valid) begin
                        entry_next[7:0] = sw;
                        state_next      = S_CHECK;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (entry == PASSCODE) begin
                    fail_next  = 2'd0;
                    timer_next = OPEN_CYCLES - 16'd1;
                    state_next = S_OPEN;
                end else begin
                    state_next = S_FAIL;
                end
            end
            S_OPEN: begin
                if (timer == 16'd0) begin
                    entry_next = ENTRY_EMPTY;
                    state_next = S_E0;
                end else begin
                    timer_next = timer - 16'd1;
                end
            end
            S_FAIL: begin
                fail_next = fail_inc;
                if (32'(fail_inc) >= MAX_FAIL) begin
                    timer_next = LOCK_CYCLES - 16'd1;
                    state_next = S_LOCKOUT;
                end else begin
                    entry_next = ENTRY_EMPTY;
                    state_next = S_E0;
                end
            end
            S_LOCKOUT: begin
                if (timer == 16'd0) begin
                    fail_next  = 2'd0;
                    entry_next = ENTRY_EMPTY;
                    state_next = S_E0;
                end else begin
                    timer_next = timer - 16'd1;
                end
            end
            default: begin
                entry_next = ENTRY_EMPTY;
                state_next = S_E0;
            end
        endcase
    end

    // Remaining outputs decode directly from the registered state.
    always_comb begin
        stage = 2'd0;
        case (state)
            S_E1:                    stage = 2'd1;
            S_E2:                    stage = 2'd2;
            S_CHECK, S_OPEN, S_FAIL: stage = 2'd3;
            default:                 stage = 2'd0;
        endcase
    end

    assign unlocked   = (state == S_OPEN);
    assign locked_out = (state == S_LOCKOUT);
    assign busy       = (state == S_CHECK) || (state == S_OPEN) ||
                        (state == S_FAIL)  || (state == S_LOCKOUT);

endmodule

// File: tb/tb_passcode_controller.sv
// tb/tb_passcode_controller.sv - directed scoreboard bench for passcode_controller
module tb_passcode_controller;

    localparam logic [15:0] OPEN_N = 16'd5;
    localparam logic [15:0] LOCK_N = 16'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    logic        clr;
    logic [7:0]  sw;
    logic [1:0]  stage;
    logic [23:0] entry;
    logic        unlocked;
    logic        locked_out;
    logic [1:0]  fail_cnt;
    logic        err;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    passcode_controller #(
        .PASSCODE(24'h123456),
        .MAX_FAIL(3),
        .OPEN_CYCLES(OPEN_N),
        .LOCK_CYCLES(LOCK_N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .push(push),
        .clr(clr),
        .sw(sw),
        .stage(stage),
        .entry(entry),
        .unlocked(unlocked),
        .locked_out(locked_out),
        .fail_cnt(fail_cnt),
        .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected stage/entry are queued as the key press is driven, then
    // popped once the capturing edge has passed.
    task automatic press(input logic [7:0] v, input logic [1:0] exp_stage, input logic [23:0] exp_entry);
        exp_q.push_back(32'(exp_stage));
        exp_q.push_back(32'(exp_entry));
        sw   = v;
        push = 1'b1;
        tick();
        check("press_stage", 32'(stage), exp_q.pop_front());
        check("press_entry", 32'(entry), exp_q.pop_front());
        push = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("idle_bound", 32'(busy), 32'd0);
    endtask

    task automatic wrong_code(input logic [1:0] exp_fail_after);
        press(8'h00, 2'd1, 24'h00FFFF);
        press(8'h00, 2'd2, 24'h0000FF);
        press(8'h00, 2'd3, 24'h000000);
        tick();
        check("fail_cnt", 32'(fail_cnt), 32'(exp_fail_after));
    endtask

    initial begin
        int cnt;
        rst  = 1'b1;
        push = 1'b0;
        clr  = 1'b0;
        sw   = 8'h00;
        tick();
        tick();
        check("rst_stage", 32'(stage), 32'd0);
        check("rst_entry", 32'(entry), 32'hFFFFFF);
        check("rst_flags", {28'd0, unlocked, locked_out, err, busy}, 32'd0);
        check("rst_fail", 32'(fail_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Correct code and OPEN hold time
        press(8'h12, 2'd1, 24'h12FFFF);
        press(8'h34, 2'd2, 24'h1234FF);
        press(8'h56, 2'd3, 24'h123456);
        cnt = 0;
        while (unlocked === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        check("open_len", 32'(cnt), 32'(OPEN_N));
        check("open_ret_stage", 32'(stage), 32'd0);
        check("open_ret_entry", 32'(entry), 32'hFFFFFF);

        // Invalid BCD in E1
        press(8'h12, 2'd1, 24'h12FFFF);
        sw   = 8'h3A;
        push = 1'b1;
        tick();
        check("bcd_err", 32'(err), 32'd1);
        check("bcd_stage", 32'(stage), 32'd1);
        push = 1'b0;
        tick();
        check("bcd_err_clear", 32'(err), 32'd0);
        check("bcd_entry_pair1", 32'(entry[15:8]), 32'hFF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_e1_stage", 32'(stage), 32'd0);
        tick();

        // Wrong codes into lockout
        wrong_code(2'd1);
        check("fail1_stage", 32'(stage), 32'd0);
        wrong_code(2'd2);
        wrong_code(2'd3);
        check("lock_enter", 32'(locked_out), 32'd1);
        check("lock_stage", 32'(stage), 32'd0);
        cnt = 0;
        while (locked_out === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        check("lock_len", 32'(cnt), 32'(LOCK_N));
        check("lock_fail_clear", 32'(fail_cnt), 32'd0);

        // clr beats a simultaneous push in E2
        wrong_code(2'd1);
        press(8'h12, 2'd1, 24'h12FFFF);
        press(8'h34, 2'd2, 24'h1234FF);
        sw   = 8'h56;
        push = 1'b1;
        clr  = 1'b1;
        tick();
        check("clr_stage", 32'(stage), 32'd0);
        check("clr_entry", 32'(entry), 32'hFFFFFF);
        check("clr_err", 32'(err), 32'd0);
        check("clr_fail", 32'(fail_cnt), 32'd1);
        push = 1'b0;
        clr  = 1'b0;
        tick();

        // Pushes while locked out are ignored
        wrong_code(2'd2);
        wrong_code(2'd3);
        for (int i = 0; i < 2; i++) begin
            sw   = 8'h12;
            push = 1'b1;
            tick();
            check("lock_push_err", 32'(err), 32'd0);
            check("lock_push_state", {30'd0, locked_out, stage != 2'd0}, 32'd2);
            push = 1'b0;
            tick();
        end
        wait_idle();
        press(8'h78, 2'd1, 24'h78FFFF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();

        // Pushes while open are ignored
        press(8'h12, 2'd1, 24'h12FFFF);
        press(8'h34, 2'd2, 24'h1234FF);
        press(8'h56, 2'd3, 24'h123456);
        sw   = 8'h99;
        push = 1'b1;
        tick();
        check("open_push_err", 32'(err), 32'd0);
        check("open_push_state", {29'd0, unlocked, stage}, 32'h7);
        push = 1'b0;
        tick();
        wait_idle();
        check("open_push_entry", 32'(entry), 32'hFFFFFF);
        press(8'h78, 2'd1, 24'h78FFFF);

        // Push held high through reset release
        push = 1'b1;
        sw   = 8'h12;
        rst  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("held_stage", 32'(stage), 32'd0);
        check("held_entry", 32'(entry), 32'hFFFFFF);
        push = 1'b0;
        tick();
        press(8'h12, 2'd1, 24'h12FFFF);

        // Reset during lockout
        clr = 1'b1;
        tick();
        clr = 1'b0;
        wrong_code(2'd1);
        wrong_code(2'd2);
        wrong_code(2'd3);
        check("pre_rst_lock", 32'(locked_out), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_flags", {28'd0, unlocked, locked_out, err, busy}, 32'd0);
        check("midrst_fail", 32'(fail_cnt), 32'd0);
        check("midrst_stage", 32'(stage), 32'd0);
        rst = 1'b0;
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/passcode_controller.md
PASSCODE_CONTROLLER -- requirements
Module: passcode_controller

Interface
REQ-001 SHALL have parameter PASSCODE, default 24'h123456, meaning the six-digit BCD code; pair 0 is [23:16], pair 1 is [15:8], pair 2 is [7:0].
REQ-002 SHALL have parameter MAX_FAIL, default 3, meaning the number of consecutive wrong codes (1..3) that triggers lockout.
REQ-003 SHALL have parameter OPEN_CYCLES, default 16'd50000, meaning the unlocked hold time in clk cycles (>=1).
REQ-004 SHALL have parameter LOCK_CYCLES, default 16'd65535, meaning the lockout time in clk cycles (>=1).
REQ-005 SHALL have the following ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  enter key, already synchronised level; acted on at its rising edge.
- clr  in  1  abort the current entry, level-sensitive.
- sw  in  8  BCD digit pair; [7:4] is the tens digit, [3:0] is the units digit.
- stage  out  2  number of pairs captured so far (0..3).
- entry  out  24  captured pairs; uncaptured pairs read 24'hFFFFFF-filled.
- unlocked  out  1  high while in the OPEN state.
- locked_out  out  1  high while in the LOCKOUT state.
- fail_cnt  out  2  count of consecutive failures.
- err  out  1  one-cycle pulse on a rejected push.
- busy  out  1  high in CHECK, OPEN, FAIL and LOCKOUT.

Function
REQ-006 SHALL detect a push edge as push=1 while a registered copy push_q=0; push_q updates every cycle.
REQ-007 SHALL implement states E0, E1, E2, CHECK, OPEN, FAIL and LOCKOUT, with all transitions registered.
REQ-008 SHALL, on a push edge in E0/E1/E2, check sw: if either nibble is >9, stay in the state, leave entry unchanged, and pulse err for 1 cycle.
REQ-009 SHALL, on a valid push edge in E0, write sw into entry[23:16] and go to E1; in E1, write entry[15:8] and go to E2; in E2, write entry[7:0] and go to CHECK.
REQ-010 SHALL drive stage to 0, 1, 2 or 3 in E0, E1, E2 and CHECK/OPEN/FAIL respectively; stage SHALL be 0 in LOCKOUT.
REQ-011 SHALL, in CHECK (exactly 1 cycle), go to OPEN if entry==PASSCODE, else go to FAIL.
REQ-012 SHALL, on entering OPEN, clear fail_cnt, load the timer with OPEN_CYCLES-1, and hold unlocked=1 for exactly OPEN_CYCLES cycles, then go to E0.
REQ-013 SHALL, in FAIL (exactly 1 cycle), increment fail_cnt, saturating at 3.
REQ-014 SHALL leave FAIL for LOCKOUT if the incremented fail_cnt is >=MAX_FAIL, else for E0.
REQ-015 SHALL hold locked_out=1 for exactly LOCK_CYCLES cycles in LOCKOUT, then clear fail_cnt and go to E0.
REQ-016 SHALL reset entry to 24'hFFFFFF on every entry into E0.
REQ-017 SHALL ignore push edges while busy=1: no state change, no err; such an edge is not remembered.
REQ-018 SHALL treat push held high across a return to E0 as no edge; a new low-to-high transition is required.
REQ-019 SHALL, when clr=1 in E1/E2, go to E0 next cycle without changing fail_cnt.
REQ-020 SHALL ignore clr in E0, CHECK, OPEN, FAIL and LOCKOUT.
REQ-021 SHALL give clr priority over a simultaneous push edge in E1/E2, with no capture and no err.
REQ-022 SHALL implement the timer as a single 16-bit down-counter shared by OPEN and LOCKOUT, with no wrap-around; the state exits when the count is 0.
REQ-023 SHALL register all outputs or decode them from registered state only.

Reset
REQ-024 SHALL, on rst=1 at a clk edge, set the state to E0, entry to 24'hFFFFFF, stage to 0, fail_cnt to 0, unlocked/locked_out/err/busy to 0, and the timer to 0.
REQ-025 SHALL set push_q to 1 on reset so that a push held through reset does not register.
REQ-026 SHALL, if rst is asserted mid-operation (any state, including OPEN or LOCKOUT), abort immediately with no residual fail count.

Verification
REQ-027 SHALL pass a correct-code test: push sw=12, 34, 56 -> stage 1,2,3; CHECK; unlocked=1 for exactly OPEN_CYCLES cycles; then E0 with entry=24'hFFFFFF.
REQ-028 SHALL pass a wrong-code/lockout test: three entries of 00,00,00 with MAX_FAIL=3 -> fail_cnt 1,2,3; locked_out=1 for LOCK_CYCLES cycles; fail_cnt=0 afterwards.
REQ-029 SHALL pass an invalid-BCD test: push with sw=8'h3A in E1 -> err pulse of 1 cycle, stage stays 1, entry[15:8] stays 8'hFF.
REQ-030 SHALL pass a clr test: clr and a push edge in the same cycle in E2 -> E0, entry=24'hFFFFFF, fail_cnt unchanged, no err.
REQ-031 SHALL pass a held-push/reset test: push held high through rst deassertion -> no capture until push goes low then high again.
REQ-032 SHALL pass a busy-push test: push edges during OPEN and LOCKOUT -> ignored; the first edge after return to E0 captures into entry[23:16].
